// File: rtl/cell_row_prefetcher.sv
// Per-pixel cell lookup from a ping-pong row buffer that is refilled from SRAM ahead of display.
// Optional border colour for out-of-grid pixels: define CELL_ROW_PREFETCHER_BORDER_EN.
module cell_row_prefetcher #(
   parameter int CELL_W    = 8,
   parameter int CELL_H    = 8,
   parameter int GRID_COLS = 40,
   parameter int GRID_ROWS = 30,
   parameter int CELL_BITS = 1,
   parameter int ADDR_W    = 11,
   parameter int BASE_ADDR = 0,
   parameter logic [CELL_BITS-1:0] BORDER_VALUE = '0
) (
   input  logic                 clk_74a,
   input  logic                 reset,
   input  logic [9:0]           visible_x,
   input  logic [9:0]           visible_y,
   input  logic                 frame_start,
   input  logic                 line_start,
   input  logic [9:0]           line_y,
   output logic                 sram_req,
   output logic [ADDR_W-1:0]    sram_addr,
   input  logic                 sram_ready,
   input  logic                 sram_rvalid,
   input  logic [CELL_BITS-1:0] sram_rdata,
   output logic [CELL_BITS-1:0] pixel_out,
   output logic                 underrun
);
   localparam int CW_SH = $clog2(CELL_W);
   localparam int CH_SH = $clog2(CELL_H);
   localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t               r_state, w_state_nxt;
   logic [9:0]           r_row, w_row_nxt;
   logic [COL_W-1:0]     r_col, w_col_nxt;
   logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
   logic [1:0]           r_valid, w_valid_nxt;
   logic                 r_front, w_front_nxt;
   logic                 r_discard, w_discard_nxt;
   logic                 r_pend, w_pend_nxt;
   logic                 r_underrun, w_underrun_nxt;
   logic [CELL_BITS-1:0] r_pixel, w_pixel_nxt;
   logic [CELL_BITS-1:0] r_buf [2][GRID_COLS];
   logic                 w_wr;

   logic [9:0] w_line_row, w_start_row, w_px_col, w_px_row;
   logic       w_tile_line, w_abort, w_start, w_inflight, w_active, w_in_grid;

   assign w_line_row  = line_y >> CH_SH;
   assign w_tile_line = line_start && !frame_start && ((line_y & 10'(CELL_H-1)) == 10'd0)
                        && (int'(w_line_row) < GRID_ROWS);
   assign w_abort     = frame_start || w_tile_line;
   assign w_start     = frame_start || (w_tile_line && (int'(w_line_row) + 1 < GRID_ROWS));
   assign w_start_row = frame_start ? 10'd0 : w_line_row + 10'd1;
   // A read accepted this cycle or still awaiting rvalid must be drained before refetching.
   assign w_inflight  = (r_state == S_REQ && sram_ready) || (r_state == S_WAIT && !sram_rvalid)
                        || (r_discard && !sram_rvalid);
   assign w_active    = (r_state != S_IDLE) || r_pend;

   always_comb begin
      w_state_nxt    = r_state;
      w_row_nxt      = r_row;
      w_col_nxt      = r_col;
      w_valid_nxt    = r_valid;
      w_front_nxt    = r_front;
      w_discard_nxt  = r_discard && !sram_rvalid;
      w_pend_nxt     = r_pend;
      w_underrun_nxt = r_underrun;
      w_wr           = 1'b0;
      if (w_abort) begin
         w_discard_nxt = w_inflight;
         w_state_nxt   = S_IDLE;
         w_pend_nxt    = 1'b0;
         if (frame_start) begin
            w_valid_nxt = 2'b00;
         end else begin
            w_front_nxt = ~r_front;
            if (!r_valid[~r_front] || w_active) w_underrun_nxt = 1'b1;
         end
         if (w_start) begin
            w_row_nxt                 = w_start_row;
            w_col_nxt                 = '0;
            w_valid_nxt[~w_front_nxt] = 1'b0;
            w_pend_nxt                = 1'b1;
         end
      end else begin
         case (r_state)
            S_REQ:  if (sram_ready) w_state_nxt = S_WAIT;
            S_WAIT: if (sram_rvalid) begin
               w_wr = 1'b1;
               if (r_col == COL_W'(GRID_COLS-1)) begin
                  w_valid_nxt[~r_front] = 1'b1;
                  w_state_nxt           = S_IDLE;
               end else begin
                  w_col_nxt   = r_col + 1'b1;
                  w_state_nxt = S_REQ;
               end
            end
            default: ;
         endcase
      end
      // Pending fetch launches once no discarded read remains outstanding.
      if (w_pend_nxt && !w_discard_nxt) begin
         w_pend_nxt  = 1'b0;
         w_state_nxt = S_REQ;
      end
   end

   assign w_addr_nxt = (w_state_nxt == S_REQ)
                       ? ADDR_W'(BASE_ADDR + int'(w_row_nxt) * GRID_COLS + int'(w_col_nxt))
                       : r_addr;

   assign w_px_col = visible_x >> CW_SH;
   assign w_px_row = visible_y >> CH_SH;

   always_comb begin
      w_in_grid   = (int'(w_px_col) < GRID_COLS) && (int'(w_px_row) < GRID_ROWS);
      w_pixel_nxt = '0;
      if (w_in_grid) begin
         if (r_valid[r_front]) w_pixel_nxt = r_buf[r_front][w_px_col[COL_W-1:0]];
      end
`ifdef CELL_ROW_PREFETCHER_BORDER_EN
      else w_pixel_nxt = BORDER_VALUE;
`endif
   end

   always_ff @(posedge clk_74a or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_addr     <= '0;
         r_valid    <= 2'b00;
         r_front    <= 1'b0;
         r_discard  <= 1'b0;
         r_pend     <= 1'b0;
         r_underrun <= 1'b0;
         r_pixel    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_row      <= w_row_nxt;
         r_col      <= w_col_nxt;
         r_addr     <= w_addr_nxt;
         r_valid    <= w_valid_nxt;
         r_front    <= w_front_nxt;
         r_discard  <= w_discard_nxt;
         r_pend     <= w_pend_nxt;
         r_underrun <= w_underrun_nxt;
         r_pixel    <= w_pixel_nxt;
      end
   end

   // Buffer storage needs no reset: the valid flags gate every read.
   always_ff @(posedge clk_74a) begin
      if (w_wr) r_buf[~r_front][r_col] <= sram_rdata;
   end

   assign sram_req  = (r_state == S_REQ);
   assign sram_addr = r_addr;
   assign pixel_out = r_pixel;
   assign underrun  = r_underrun;
endmodule

// File: tb/tb_cell_row_prefetcher.sv
// Directed bench for cell_row_prefetcher: default-parameter instance plus a 4-bit/wrapping-address instance.
module tb_cell_row_prefetcher;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // default instance
   logic [9:0]  vx, vy, ly;
   logic        fs, ls;
   logic        req0, rv0, ur0;
   logic        rdy0 = 1'b1;
   logic [10:0] addr0, qa0;
   logic [0:0]  rd0 = '0;
   logic [0:0]  px0;
   int          lat0 = 2;
   int          cnt0 = 0;
   logic        busy0 = 1'b0;
   int          q0[$];

   // wide-cell, wrapping-address instance
   logic [9:0]  vx6, vy6, ly6;
   logic        fs6, ls6;
   logic        req6, rv6, ur6;
   logic        rdy6 = 1'b1;
   logic [10:0] addr6, qa6;
   logic [3:0]  rd6 = '0;
   logic [3:0]  px6;
   int          cnt6 = 0;
   logic        busy6 = 1'b0;
   int          q6[$];

   cell_row_prefetcher dut0 (
      .clk_74a(clk), .reset(rst), .visible_x(vx), .visible_y(vy),
      .frame_start(fs), .line_start(ls), .line_y(ly),
      .sram_req(req0), .sram_addr(addr0), .sram_ready(rdy0),
      .sram_rvalid(rv0), .sram_rdata(rd0), .pixel_out(px0), .underrun(ur0)
   );

   cell_row_prefetcher #(.CELL_BITS(4), .CELL_W(16), .GRID_COLS(20), .BASE_ADDR(2040), .ADDR_W(11)) dut6 (
      .clk_74a(clk), .reset(rst), .visible_x(vx6), .visible_y(vy6),
      .frame_start(fs6), .line_start(ls6), .line_y(ly6),
      .sram_req(req6), .sram_addr(addr6), .sram_ready(rdy6),
      .sram_rvalid(rv6), .sram_rdata(rd6), .pixel_out(px6), .underrun(ur6)
   );

   // SRAM models: accept on req&ready, return data = low address bits after lat cycles
   always @(posedge clk) begin
      rv0 <= 1'b0;
      if (rst) begin
         busy0 <= 1'b0;
      end else begin
         if (busy0) begin
            if (cnt0 == 1) begin rv0 <= 1'b1; rd0 <= qa0[0]; busy0 <= 1'b0; end
            else cnt0 <= cnt0 - 1;
         end
         if (req0 && rdy0) begin
            busy0 <= 1'b1; cnt0 <= lat0 - 1; qa0 <= addr0; q0.push_back(int'(addr0));
         end
      end
   end

   always @(posedge clk) begin
      rv6 <= 1'b0;
      if (rst) begin
         busy6 <= 1'b0;
      end else begin
         if (busy6) begin
            if (cnt6 == 1) begin rv6 <= 1'b1; rd6 <= qa6[3:0]; busy6 <= 1'b0; end
            else cnt6 <= cnt6 - 1;
         end
         if (req6 && rdy6) begin
            busy6 <= 1'b1; cnt6 <= 1; qa6 <= addr6; q6.push_back(int'(addr6));
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic line0(input int y);
      ls = 1'b1; ly = 10'(y);
      @(negedge clk);
      ls = 1'b0;
   endtask

   task automatic pix0(input int x, input int y, input int exp, input string tag);
      vx = 10'(x); vy = 10'(y);
      @(negedge clk);
      chk(tag, 32'(px0), 32'(exp));
   endtask

   task automatic pix6(input int x, input int y, input int exp, input string tag);
      vx6 = 10'(x); vy6 = 10'(y);
      @(negedge clk);
      chk(tag, 32'(px6), 32'(exp));
   endtask

   task automatic chk_log0(input string tag, input int base, input int first, input int n);
      chk({tag, "_count"}, 32'(q0.size() - base), 32'(n));
      for (int i = 0; i < n && base + i < q0.size(); i++)
         chk({tag, "_addr"}, 32'(q0[base + i]), 32'(first + i));
   endtask

   initial begin
      int base, viol, waited;
      logic seen, got;
      rst = 1'b1; fs = 0; ls = 0; ly = 0; vx = 0; vy = 0;
      fs6 = 0; ls6 = 0; ly6 = 0; vx6 = 0; vy6 = 0;
      tick(3);
      chk("rst_req", 32'(req0), 0);
      chk("rst_addr", 32'(addr0), 0);
      chk("rst_pixel", 32'(px0), 0);
      chk("rst_underrun", 32'(ur0), 0);
      chk("rst_addr6", 32'(addr6), 0);
      rst = 1'b0;
      tick(2);

      // T1: row 0 fetch, swap, pixel lookup
      fs = 1'b1; @(negedge clk); fs = 1'b0;
      tick(300);
      chk_log0("t1_row0", 0, 0, 40);
      line0(0);
      chk("t1_underrun", 32'(ur0), 0);
      pix0(16, 3, 0, "t1_px16_3");
      pix0(24, 0, 1, "t1_px24_0");
      pix0(8, 7, 1, "t1_px8_7");

      // T2: row 1 prefetched during row 0, then row 2 during row 1
      tick(300);
      chk_log0("t2_row1", 40, 40, 40);
      line0(8);
      chk("t2_underrun", 32'(ur0), 0);
      pix0(0, 8, 0, "t2_px0_8");
      pix0(8, 9, 1, "t2_px8_9");
      pix0(304, 15, 0, "t2_px304_15");
      pix0(312, 15, 1, "t2_px312_15");
      tick(300);
      chk_log0("t2_row2", 80, 80, 40);

      // T4: grid boundaries, evaluated at full width
      pix0(319, 8, 1, "t4_lastcol");
      pix0(312, 239, 1, "t4_lastrow");
      pix0(320, 8, 0, "t4_x320");
      pix0(0, 240, 0, "t4_y240");
      pix0(520, 8, 0, "t4_x520_notrunc");

      // T5: frame_start + line_start together mid-fetch of row 5
      base = q0.size();
      line0(32);
      chk("t5_underrun_swap", 32'(ur0), 0);
      tick(10);
      chk("t5_row5_start", (q0.size() > base) ? 32'(q0[base]) : 32'hFFFF, 200);
      tick(40);
      fs = 1'b1; ls = 1'b1; ly = 10'd40;
      @(negedge clk);
      fs = 1'b0; ls = 1'b0;
      base = q0.size();
      pix0(24, 8, 0, "t5_px_invalid");
      tick(300);
      chk_log0("t5_refetch", base, 0, 40);
      chk("t5_no_swap_underrun", 32'(ur0), 0);
      line0(0);
      chk("t5_underrun_after", 32'(ur0), 0);
      pix0(24, 0, 1, "t5_px24_0");

      // T6: 4-bit cells, 16-pixel cells, addresses wrapping past 2047
      fs6 = 1'b1; @(negedge clk); fs6 = 1'b0;
      tick(200);
      chk("t6_count", 32'(q6.size()), 20);
      for (int i = 0; i < 20 && i < q6.size(); i++)
         chk("t6_addr", 32'(q6[i]), 32'((2040 + i) % 2048));
      ls6 = 1'b1; ly6 = 10'd0; @(negedge clk); ls6 = 1'b0;
      chk("t6_underrun", 32'(ur6), 0);
      pix6(0, 0, 8, "t6_px_col0");
      pix6(80, 3, 13, "t6_px_col5");
      pix6(128, 0, 0, "t6_px_col8");
      pix6(304, 7, 11, "t6_px_col19");
      pix6(320, 0, 0, "t6_px_x320");

      // T3: slow SRAM, row boundary reached mid-fetch
      rst = 1'b1; tick(2); rst = 1'b0;
      q0.delete();
      lat0 = 20;
      fs = 1'b1; @(negedge clk); fs = 1'b0;
      tick(1000);
      chk_log0("t3_row0", 0, 0, 40);
      line0(0);
      chk("t3_underrun_y0", 32'(ur0), 0);
      tick(50);
      waited = 0;
      while (!(busy0 && cnt0 > 5) && waited < 200) begin
         @(negedge clk); waited++;
      end
      chk("t3_found_outstanding", 32'(busy0 && cnt0 > 5), 1);
      line0(8);
      chk("t3_underrun_set", 32'(ur0), 1);
      seen = 1'b0; got = 1'b0; viol = 0; waited = 0;
      while (!got && waited < 100) begin
         if (req0) begin
            if (!seen) viol++;
            else got = 1'b1;
         end
         if (rv0) seen = 1'b1;
         if (!got) begin @(negedge clk); waited++; end
      end
      chk("t3_req_held_low", 32'(viol), 0);
      chk("t3_discard_seen", 32'(seen), 1);
      chk("t3_refetch_started", 32'(got), 1);
      chk("t3_row2_addr", 32'(addr0), 80);
      pix0(8, 8, 0, "t3_px8_8_invalid");
      pix0(0, 8, 0, "t3_px0_8_invalid");
      tick(1000);
      chk("t3_underrun_sticky", 32'(ur0), 1);
      chk("t3_last_addr", (q0.size() > 0) ? 32'(q0[q0.size() - 1]) : 32'hFFFF, 119);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cell_row_prefetcher.md
Name: cell_row_prefetcher

Overview:
- Parametrised successor to the cell-grid pixel driver. Serves a CELL_BITS-wide cell value per visible pixel from a GRID_COLS x GRID_ROWS cell grid held in SRAM.
- Removes the per-pixel combinational SRAM access. Whole cell rows are prefetched into a ping-pong line buffer through a request/grant/valid SRAM handshake, during the scanlines before each row is displayed.
- Sits between the video timing generator and the shared SRAM arbiter.

Parameters:
- CELL_W, 8, cell width in pixels; power of two.
- CELL_H, 8, cell height in pixels; power of two.
- GRID_COLS, 40, cells per row.
- GRID_ROWS, 30, cell rows per frame.
- CELL_BITS, 1, bits per cell (pixel value width).
- ADDR_W, 11, SRAM address width.
- BASE_ADDR, 0, SRAM address of cell (0,0).
- BORDER_VALUE, 0, pixel value outside the grid (used only with the optional feature).

Ports:
- clk_74a  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- visible_x  in  10  current pixel column.
- visible_y  in  10  current pixel row.
- frame_start  in  1  one-cycle pulse, once per frame, before line 0.
- line_start  in  1  one-cycle pulse in hblank preceding scanline line_y.
- line_y  in  10  number of the upcoming scanline; sampled on line_start.
- sram_req  out  1  read request; held until granted.
- sram_addr  out  ADDR_W  read address; stable while sram_req=1.
- sram_ready  in  1  grant; a read is accepted on a cycle where sram_req and sram_ready are both 1.
- sram_rvalid  in  1  read data valid, one or more cycles after acceptance.
- sram_rdata  in  CELL_BITS  read data.
- pixel_out  out  CELL_BITS  cell value for (visible_x, visible_y), registered.
- underrun  out  1  sticky: a row fetch did not complete before its row was displayed.

Behaviour:

Reset values:
- sram_req=0, sram_addr=0, pixel_out=0, underrun=0.
- FSM in IDLE; both buffers marked invalid; front-buffer select = 0.

Buffers:
- Two GRID_COLS x CELL_BITS arrays (front/back), each with a valid flag.

FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ on a fetch start. Loads fetch_row and col=0, clears the back-buffer valid flag.
- REQ: sram_req=1, sram_addr = (BASE_ADDR + fetch_row*GRID_COLS + col) mod 2^ADDR_W.
  - On sram_ready: deassert sram_req the next cycle; -> WAIT.
  - Exactly one read is outstanding at a time.
- WAIT: on sram_rvalid, write back[col] = sram_rdata.
  - If col == GRID_COLS-1: set back valid; -> IDLE.
  - Otherwise: col+1; -> REQ.
- sram_rvalid in IDLE or REQ is ignored.

Fetch starts:
- frame_start: abort any fetch in progress, invalidate both buffers, start fetch of row 0.
- line_start with line_y mod CELL_H == 0 and line_y/CELL_H < GRID_ROWS:
  1. Swap front/back.
  2. If the new front is invalid, or a fetch was still active, set underrun. Any active fetch is aborted.
  3. If line_y/CELL_H + 1 < GRID_ROWS, start fetch of row line_y/CELL_H+1.
- line_start on any other line: no action.
- frame_start and line_start in the same cycle: frame_start wins; line_start is ignored.

Abort:
- Return to IDLE without asserting sram_req further.
- A read already accepted still has its rvalid consumed and discarded, so the next fetch does not start until the discard completes.

Pixel path (1-cycle latency):
- col = visible_x / CELL_W (shift), row = visible_y / CELL_H.
- If col < GRID_COLS, row < GRID_ROWS and front valid: pixel_out <= front[col]. Otherwise pixel_out <= 0.
- Ranges are computed at full 10-bit width; no truncation before comparison.

Other rules:
- underrun clears only on reset.
- Reset mid-fetch returns all state to reset values immediately; the SRAM arbiter is required to drop an accepted-but-undelivered read on reset.

Optional Feature:
- Macro: CELL_ROW_PREFETCHER_BORDER_EN.
- Defined: pixels outside the grid output BORDER_VALUE. Pixels inside the grid with an invalid front buffer still output 0.
- Undefined: all out-of-grid pixels output 0; BORDER_VALUE is unused.

Test Plan:
1. Reset, frame_start; SRAM model grants immediately, rvalid 2 cycles later, data = addr[0].
   -> 40 requests at addresses 0..39.
   -> line_start line_y=0 swaps with underrun=0.
   -> visible (16,3) yields pixel_out = 0 (addr 2) one cycle later; (24,0) yields 1.
2. Same model; line_start line_y=8.
   -> fetch of row 2 at addresses 80..119.
   -> row 1 displays data from addresses 40..79.
3. Slow SRAM: rvalid 20 cycles; line_start line_y=8 arrives mid-fetch.
   -> underrun=1 and stays 1.
   -> row 1 pixels output 0.
   -> the pending rvalid is discarded.
   -> sram_req stays 0 until the row-2 fetch starts.
4. visible_x=320 or visible_y=240.
   -> pixel_out = 0; with BORDER_EN and BORDER_VALUE=1, pixel_out = 1.
5. frame_start and line_start asserted together mid-fetch of row 5.
   -> fetch restarts at address 0, both buffers invalid, no swap.
6. CELL_BITS=4, CELL_W=16, GRID_COLS=20, BASE_ADDR=2040, ADDR_W=11.
   -> the row-0 fetch addresses wrap to 2040..2047, then 0..11.
   -> pixel_out is 4 bits wide and matches the fetched data.
